// File: rtl/cdb_arbiter_if.sv
// Bundle of the three execution-unit result ports and the common data bus.
// master = producer/completion side, slave = the arbiter itself.
interface cdb_arbiter_if;
  logic        ld_valid;
  logic [39:0] ld_data;
  logic        ld_ready;
  logic        mu_valid;
  logic [39:0] mu_data;
  logic        mu_ready;
  logic        ad_valid;
  logic [39:0] ad_data;
  logic        ad_ready;
  logic        cdb_hold;
  logic        cdb_valid;
  logic [39:0] cdb_data;
  logic [1:0]  cdb_src;
  logic        busy;

  modport master (
    output ld_valid, ld_data, mu_valid, mu_data, ad_valid, ad_data, cdb_hold,
    input  ld_ready, mu_ready, ad_ready, cdb_valid, cdb_data, cdb_src, busy
  );

  modport slave (
    input  ld_valid, ld_data, mu_valid, mu_data, ad_valid, ad_data, cdb_hold,
    output ld_ready, mu_ready, ad_ready, cdb_valid, cdb_data, cdb_src, busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three private result FIFOs (load, mult, add)
// drained round-robin into a single registered CDB word with hold backpressure.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [2:0]        in_valid;
  logic [2:0][39:0]  in_data;
  logic [2:0][39:0]  head;
  logic [2:0]        ready;
  logic [2:0]        nonempty;
  logic [2:0]        push;
  logic [2:0]        pop;
  logic [1:0]        rr_ptr;
  logic [1:0]        gnt_idx;
  logic              gnt_valid;
  logic              out_free;
  logic              cdb_valid_q;
  logic [39:0]       cdb_data_q;
  logic [1:0]        cdb_src_q;

  // Source index 0 = load, 1 = mult, 2 = add.
  assign in_valid = {bus.ad_valid, bus.mu_valid, bus.ld_valid};
  assign in_data  = {bus.ad_data, bus.mu_data, bus.ld_data};

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [39:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Ready looks only at the registered count, so a full queue never
    // accepts in the cycle it pops and cdb_hold has no path to ready.
    assign ready[g]    = (count < FULL);
    assign nonempty[g] = (count != '0);
    assign push[g]     = in_valid[g] && ready[g];
    assign pop[g]      = out_free && gnt_valid && (gnt_idx == 2'(g));
    assign head[g]     = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[g]) begin
        mem[wr_ptr] <= in_data[g];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop[g]) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push[g], pop[g]})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign out_free = !cdb_valid_q || !bus.cdb_hold;

  // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
  always_comb begin
    logic [1:0] cand;
    cand      = 2'd0;
    gnt_valid = 1'b0;
    gnt_idx   = rr_ptr;
    for (int k = 2; k >= 0; k--) begin
      cand = add_mod3(rr_ptr, 2'(k));
      if (nonempty[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= 2'd0;
      rr_ptr      <= 2'd0;
    end else if (out_free) begin
      if (gnt_valid) begin
        cdb_valid_q <= 1'b1;
        cdb_data_q  <= head[gnt_idx];
        cdb_src_q   <= gnt_idx;
        rr_ptr      <= add_mod3(gnt_idx, 2'd1);
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ld_ready  = ready[0];
  assign bus.mu_ready  = ready[1];
  assign bus.ad_ready  = ready[2];
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.busy      = (|nonempty) || cdb_valid_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-source scoreboard queues fed on
// accepted pushes and drained on every CDB transfer, plus directed scenarios.
module tb_cdb_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int ad_push_cnt  = 0;

  logic [39:0] q_ld[$];
  logic [39:0] q_mu[$];
  logic [39:0] q_ad[$];
  logic [1:0]  log_src[$];
  logic [39:0] log_data[$];
  int          log_cyc[$];

  cdb_arbiter_if bus();

  cdb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Scoreboard: transfers are checked before this edge's pushes are recorded.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cdb_valid && !bus.cdb_hold) begin
        checkOutput("src_range", 64'(bus.cdb_src < 2'd3), 64'd1);
        case (bus.cdb_src)
          2'd0: begin
            checkOutput("sb_ld_pending", 64'(q_ld.size() != 0), 64'd1);
            if (q_ld.size() != 0) checkOutput("sb_ld_data", 64'(bus.cdb_data), 64'(q_ld.pop_front()));
          end
          2'd1: begin
            checkOutput("sb_mu_pending", 64'(q_mu.size() != 0), 64'd1);
            if (q_mu.size() != 0) checkOutput("sb_mu_data", 64'(bus.cdb_data), 64'(q_mu.pop_front()));
          end
          2'd2: begin
            checkOutput("sb_ad_pending", 64'(q_ad.size() != 0), 64'd1);
            if (q_ad.size() != 0) checkOutput("sb_ad_data", 64'(bus.cdb_data), 64'(q_ad.pop_front()));
          end
          default: ;
        endcase
        log_src.push_back(bus.cdb_src);
        log_data.push_back(bus.cdb_data);
        log_cyc.push_back(cyc);
      end
      if (bus.ld_valid && bus.ld_ready) q_ld.push_back(bus.ld_data);
      if (bus.mu_valid && bus.mu_ready) q_mu.push_back(bus.mu_data);
      if (bus.ad_valid && bus.ad_ready) begin
        q_ad.push_back(bus.ad_data);
        ad_push_cnt++;
      end
    end
  end

  task automatic clearScoreboard();
    q_ld.delete();
    q_mu.delete();
    q_ad.delete();
    log_src.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    bus.ld_valid = 1'b0;
    bus.mu_valid = 1'b0;
    bus.ad_valid = 1'b0;
    bus.cdb_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clearScoreboard();
    rst_n = 1'b1;
  endtask

  // Drives the masked inputs for exactly one cycle; entered and left at posedge+1.
  task automatic applyStimulus(input logic [2:0] vmask, input logic [39:0] ld, input logic [39:0] mu,
                               input logic [39:0] ad);
    bus.ld_valid = vmask[0];
    bus.mu_valid = vmask[1];
    bus.ad_valid = vmask[2];
    bus.ld_data  = ld;
    bus.mu_data  = mu;
    bus.ad_data  = ad;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    bus.mu_valid = 1'b0;
    bus.ad_valid = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (q_ld.size() == 0 && q_mu.size() == 0 && q_ad.size() == 0 && !bus.busy) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_left", 64'(q_ld.size() + q_mu.size() + q_ad.size()), 64'd0);
    checkOutput("drain_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [39:0] words [3];
    int base_cnt;
    int base_log;
    int rot_err;
    int cnt [3];

    bus.ld_valid = 1'b0;
    bus.mu_valid = 1'b0;
    bus.ad_valid = 1'b0;
    bus.ld_data  = '0;
    bus.mu_data  = '0;
    bus.ad_data  = '0;
    bus.cdb_hold = 1'b0;

    // Reset state.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 64'(bus.cdb_valid), 64'd0);
    checkOutput("rst_data",  64'(bus.cdb_data),  64'd0);
    checkOutput("rst_src",   64'(bus.cdb_src),   64'd0);
    checkOutput("rst_busy",  64'(bus.busy),      64'd0);
    checkOutput("rst_ready", 64'({bus.ad_ready, bus.mu_ready, bus.ld_ready}), 64'h7);
    resetDut();

    // Single result and minimum latency.
    applyStimulus(3'b001, 40'h4023232323, '0, '0);
    @(negedge clk);
    checkOutput("single_no_bypass", 64'(bus.cdb_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_valid", 64'(bus.cdb_valid), 64'd1);
    checkOutput("single_data",  64'(bus.cdb_data),  64'h4023232323);
    checkOutput("single_src",   64'(bus.cdb_src),   64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_valid_drop", 64'(bus.cdb_valid), 64'd0);
    checkOutput("single_data_hold",  64'(bus.cdb_data),  64'h4023232323);
    checkOutput("single_busy_idle",  64'(bus.busy),      64'd0);
    @(posedge clk);
    #1;

    // Three-way collision right after reset.
    resetDut();
    words[0] = 40'h4023232323;
    words[1] = 40'h30000006e8;
    words[2] = 40'h2000004523;
    applyStimulus(3'b111, words[0], words[1], words[2]);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("coll_valid", 64'(bus.cdb_valid), 64'd1);
      checkOutput("coll_src",   64'(bus.cdb_src),   64'(k));
      checkOutput("coll_data",  64'(bus.cdb_data),  64'(words[k]));
    end
    @(posedge clk);
    #1;
    waitDrain(10);

    // Fault marker passes untouched.
    resetDut();
    applyStimulus(3'b001, 40'h41ffffffff, '0, '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("fault_valid", 64'(bus.cdb_valid), 64'd1);
    checkOutput("fault_data",  64'(bus.cdb_data),  64'h41ffffffff);
    checkOutput("fault_src",   64'(bus.cdb_src),   64'd0);
    @(posedge clk);
    #1;
    waitDrain(10);

    // Backpressure on the add queue.
    resetDut();
    bus.cdb_hold = 1'b1;
    base_cnt = ad_push_cnt;
    applyStimulus(3'b100, '0, '0, 40'h2000004523);
    applyStimulus(3'b100, '0, '0, 40'h2100001223);
    applyStimulus(3'b100, '0, '0, 40'h22000a2b23);
    @(negedge clk);
    checkOutput("bp_accepted",   64'(ad_push_cnt - base_cnt), 64'd3);
    checkOutput("bp_ready_low",  64'(bus.ad_ready),  64'd0);
    checkOutput("bp_held_valid", 64'(bus.cdb_valid), 64'd1);
    checkOutput("bp_held_data",  64'(bus.cdb_data),  64'h2000004523);
    @(posedge clk);
    #1;
    applyStimulus(3'b100, '0, '0, 40'h23deadbeef);
    @(negedge clk);
    checkOutput("bp_reject",     64'(ad_push_cnt - base_cnt), 64'd3);
    checkOutput("bp_still_held", 64'(bus.cdb_data), 64'h2000004523);
    @(posedge clk);
    #1;
    base_log = log_src.size();
    bus.cdb_hold = 1'b0;
    waitDrain(20);
    checkOutput("bp_drained", 64'(log_src.size() - base_log), 64'd3);

    // Fairness under saturation.
    resetDut();
    for (int c = 0; c < 30; c++) begin
      applyStimulus(3'b111, {8'h10, 32'(c)}, {8'h20, 32'(c)}, {8'h30, 32'(c)});
    end
    waitDrain(60);
    checkOutput("fair_enough", 64'(log_src.size() >= 30), 64'd1);
    rot_err = 0;
    cnt[0] = 0;
    cnt[1] = 0;
    cnt[2] = 0;
    for (int i = 0; i < 30 && i < log_src.size(); i++) begin
      if (log_src[i] != 2'(i % 3)) rot_err++;
      if (log_src[i] < 2'd3) cnt[log_src[i]]++;
      if (i > 0 && log_cyc[i] != log_cyc[i-1] + 1) rot_err++;
    end
    checkOutput("fair_rotation", 64'(rot_err), 64'd0);
    checkOutput("fair_cnt_ld", 64'(cnt[0]), 64'd10);
    checkOutput("fair_cnt_mu", 64'(cnt[1]), 64'd10);
    checkOutput("fair_cnt_ad", 64'(cnt[2]), 64'd10);

    // Reset in the middle of a held transfer.
    resetDut();
    bus.cdb_hold = 1'b1;
    applyStimulus(3'b111, 40'h4011111111, 40'h3022222222, 40'h2033333333);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_pre_valid", 64'(bus.cdb_valid), 64'd1);
    checkOutput("mid_pre_busy",  64'(bus.busy),      64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(bus.cdb_valid), 64'd0);
    checkOutput("mid_rst_data",  64'(bus.cdb_data),  64'd0);
    checkOutput("mid_rst_src",   64'(bus.cdb_src),   64'd0);
    checkOutput("mid_rst_busy",  64'(bus.busy),      64'd0);
    checkOutput("mid_rst_ready", 64'({bus.ad_ready, bus.mu_ready, bus.ld_ready}), 64'h7);
    clearScoreboard();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.cdb_hold = 1'b0;
    applyStimulus(3'b010, '0, 40'h3123454abc, '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_new_valid", 64'(bus.cdb_valid), 64'd1);
    checkOutput("mid_new_src",   64'(bus.cdb_src),   64'd1);
    checkOutput("mid_new_data",  64'(bus.cdb_data),  64'h3123454abc);
    @(posedge clk);
    #1;
    waitDrain(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
